// File: rtl/vx_afu_ctrl_if.sv
// AXI4-Lite control bus between the host and the AFU control slave.
// The host side uses the master modport and the control block uses the slave modport.
interface vx_afu_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/vx_afu_ctrl.sv
// AXI4-Lite control slave for the Vortex AFU: ap_ctrl handshake, interrupts,
// capability words and a DCR write port.
//   state   | meaning
//   WR_IDLE | awready high, waiting for a write address
//   WR_DATA | wready high, waiting for write data; the register write commits here
//   WR_RESP | bvalid high until bready
//   RD_IDLE | arready high; the AR handshake captures rdata
//   RD_DATA | rvalid high with rdata held until rready
module vx_afu_ctrl #(
  parameter int          S_AXI_ADDR_WIDTH = 8,
  parameter int          S_AXI_DATA_WIDTH = 32,
  parameter int          DCR_ADDR_WIDTH   = 12,
  parameter int          DCR_DATA_WIDTH   = 32,
  parameter logic [63:0] DEV_CAPS         = 64'h0,
  parameter logic [63:0] ISA_CAPS         = 64'h0
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_afu_ctrl_if.slave              s_axi,
  output logic                      ap_reset,
  output logic                      ap_start,
  input  logic                      ap_done,
  input  logic                      ap_idle,
  input  logic                      ap_ready,
  output logic                      interrupt,
  output logic                      dcr_wr_valid,
  output logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  output logic [DCR_DATA_WIDTH-1:0] dcr_wr_data
);
  localparam int IW = S_AXI_ADDR_WIDTH - 2;
  localparam int SW = S_AXI_DATA_WIDTH / 8;

  localparam logic [IW-1:0] A_CTRL     = IW'(0);
  localparam logic [IW-1:0] A_GIE      = IW'(1);
  localparam logic [IW-1:0] A_IER      = IW'(2);
  localparam logic [IW-1:0] A_ISR      = IW'(3);
  localparam logic [IW-1:0] A_DEV_LO   = IW'(4);
  localparam logic [IW-1:0] A_DEV_HI   = IW'(5);
  localparam logic [IW-1:0] A_ISA_LO   = IW'(6);
  localparam logic [IW-1:0] A_ISA_HI   = IW'(7);
  localparam logic [IW-1:0] A_DCR_ADDR = IW'(8);
  localparam logic [IW-1:0] A_DCR_DATA = IW'(9);

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_e;

  wr_state_e                   wr_state_q;
  rd_state_e                   rd_state_q;
  logic [IW-1:0]               waddr_q;
  logic                        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                        ap_start_q, ap_reset_q, auto_restart_q, done_q, ap_done_q;
  logic                        gie_q;
  logic [1:0]                  ier_q, isr_q, isr_d;
  logic [S_AXI_DATA_WIDTH-1:0] dcr_addr_q, dcr_addr_d;
  logic                        dcr_wr_valid_q;
  logic [DCR_ADDR_WIDTH-1:0]   dcr_wr_addr_q;
  logic [DCR_DATA_WIDTH-1:0]   dcr_wr_data_q;

  logic          wr_hs, ar_hs, wr_ctrl;
  logic [IW-1:0] rd_idx;
  logic          unused_addr_lsbs;

  assign wr_hs   = (wr_state_q == WR_DATA) && s_axi.wvalid;
  assign ar_hs   = (rd_state_q == RD_IDLE) && s_axi.arvalid;
  assign rd_idx  = s_axi.araddr[S_AXI_ADDR_WIDTH-1:2];
  assign wr_ctrl = wr_hs && (waddr_q == A_CTRL) && s_axi.wstrb[0];
  assign unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_comb begin
    rdata_d = '0;
    case (rd_idx)
      A_CTRL:     rdata_d = {24'h0, auto_restart_q, 3'b000, ap_ready, ap_idle, done_q, ap_start_q};
      A_GIE:      rdata_d = {31'h0, gie_q};
      A_IER:      rdata_d = {30'h0, ier_q};
      A_ISR:      rdata_d = {30'h0, isr_q};
      A_DEV_LO:   rdata_d = DEV_CAPS[31:0];
      A_DEV_HI:   rdata_d = DEV_CAPS[63:32];
      A_ISA_LO:   rdata_d = ISA_CAPS[31:0];
      A_ISA_HI:   rdata_d = ISA_CAPS[63:32];
      A_DCR_ADDR: rdata_d = dcr_addr_q;
      default:    rdata_d = '0;
    endcase
  end

  // Status events are applied after the host toggle so a new event is never lost.
  always_comb begin
    isr_d = isr_q;
    if (wr_hs && (waddr_q == A_ISR) && s_axi.wstrb[0]) isr_d = isr_d ^ s_axi.wdata[1:0];
    if (ier_q[0] && ap_done && !ap_done_q) isr_d[0] = 1'b1;
    if (ier_q[1] && ap_start_q && ap_ready) isr_d[1] = 1'b1;
  end

  always_comb begin
    dcr_addr_d = dcr_addr_q;
    if (wr_hs && (waddr_q == A_DCR_ADDR)) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi.wstrb[b]) dcr_addr_d[8*b +: 8] = s_axi.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q     <= WR_IDLE;
      rd_state_q     <= RD_IDLE;
      waddr_q        <= '0;
      awready_q      <= 1'b1;
      wready_q       <= 1'b0;
      bvalid_q       <= 1'b0;
      arready_q      <= 1'b1;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      ap_start_q     <= 1'b0;
      ap_reset_q     <= 1'b0;
      auto_restart_q <= 1'b0;
      done_q         <= 1'b0;
      ap_done_q      <= 1'b0;
      gie_q          <= 1'b0;
      ier_q          <= '0;
      isr_q          <= '0;
      dcr_addr_q     <= '0;
      dcr_wr_valid_q <= 1'b0;
      dcr_wr_addr_q  <= '0;
      dcr_wr_data_q  <= '0;
    end else begin
      ap_reset_q     <= 1'b0;
      dcr_wr_valid_q <= 1'b0;
      ap_done_q      <= ap_done;

      case (wr_state_q)
        WR_IDLE: if (s_axi.awvalid) begin
          waddr_q    <= s_axi.awaddr[S_AXI_ADDR_WIDTH-1:2];
          awready_q  <= 1'b0;
          wready_q   <= 1'b1;
          wr_state_q <= WR_DATA;
        end
        WR_DATA: if (s_axi.wvalid) begin
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b1;
          wr_state_q <= WR_RESP;
        end
        WR_RESP: if (s_axi.bready) begin
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
          wr_state_q <= WR_IDLE;
        end
        default: begin
          awready_q  <= 1'b1;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
          wr_state_q <= WR_IDLE;
        end
      endcase

      case (rd_state_q)
        RD_IDLE: if (s_axi.arvalid) begin
          rdata_q    <= rdata_d;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b1;
          rd_state_q <= RD_DATA;
        end
        RD_DATA: if (s_axi.rready) begin
          rvalid_q   <= 1'b0;
          arready_q  <= 1'b1;
          rd_state_q <= RD_IDLE;
        end
        default: rd_state_q <= RD_IDLE;
      endcase

      if (wr_ctrl) begin
        auto_restart_q <= s_axi.wdata[7];
        ap_reset_q     <= s_axi.wdata[4];
      end
      if (wr_ctrl && s_axi.wdata[0]) ap_start_q <= 1'b1;
      else if (ap_start_q && ap_ready && !auto_restart_q) ap_start_q <= 1'b0;

      if (ap_done) done_q <= 1'b1;
      else if (ar_hs && (rd_idx == A_CTRL)) done_q <= 1'b0;

      if (wr_hs && (waddr_q == A_GIE) && s_axi.wstrb[0]) gie_q <= s_axi.wdata[0];
      if (wr_hs && (waddr_q == A_IER) && s_axi.wstrb[0]) ier_q <= s_axi.wdata[1:0];
      isr_q      <= isr_d;
      dcr_addr_q <= dcr_addr_d;

      if (wr_hs && (waddr_q == A_DCR_DATA)) begin
        dcr_wr_valid_q <= 1'b1;
        dcr_wr_addr_q  <= dcr_addr_q[DCR_ADDR_WIDTH-1:0];
        dcr_wr_data_q  <= s_axi.wdata[DCR_DATA_WIDTH-1:0];
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  assign ap_start     = ap_start_q;
  assign ap_reset     = ap_reset_q;
  assign interrupt    = gie_q & (|isr_q);
  assign dcr_wr_valid = dcr_wr_valid_q;
  assign dcr_wr_addr  = dcr_wr_addr_q;
  assign dcr_wr_data  = dcr_wr_data_q;
endmodule

// File: tb/tb_vx_afu_ctrl.sv
// Directed bench for vx_afu_ctrl: register map, ap_ctrl handshake,
// interrupts, DCR write strobe and write-response back-pressure.
module tb_vx_afu_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        ap_reset, ap_start, ap_done, ap_idle, ap_ready, interrupt;
  logic        dcr_wr_valid;
  logic [11:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Output samples taken one cycle and two cycles after each W handshake.
  logic        s1_start, s1_rst, s1_dv, s1_irq, s2_start, s2_rst, s2_dv, s2_irq;
  logic [11:0] s1_daddr;
  logic [31:0] s1_ddata;
  logic [31:0] rd;
  logic [1:0]  rr;

  vx_afu_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  vx_afu_ctrl #(
    .S_AXI_ADDR_WIDTH(8), .S_AXI_DATA_WIDTH(32),
    .DCR_ADDR_WIDTH(12), .DCR_DATA_WIDTH(32),
    .DEV_CAPS(64'h1122334455667788), .ISA_CAPS(64'hCAFEF00D0BADC0DE)
  ) dut (
    .clk(clk), .reset(reset), .s_axi(bus),
    .ap_reset(ap_reset), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .interrupt(interrupt), .dcr_wr_valid(dcr_wr_valid),
    .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int bdelay);
    int n;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin tick(); n++; end
    if (n >= 20) check("aw_timeout", 0, 1);
    tick();
    bus.awvalid = 1'b0;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.wvalid  = 1'b1;
    n = 0;
    while (!bus.wready && n < 20) begin tick(); n++; end
    if (n >= 20) check("w_timeout", 0, 1);
    tick();
    bus.wvalid = 1'b0;
    s1_start = ap_start; s1_rst = ap_reset; s1_dv = dcr_wr_valid; s1_irq = interrupt;
    s1_daddr = dcr_wr_addr; s1_ddata = dcr_wr_data;
    for (int i = 0; i < bdelay; i++) begin
      tick();
      if (i == 0) begin
        s2_start = ap_start; s2_rst = ap_reset; s2_dv = dcr_wr_valid; s2_irq = interrupt;
      end
      check("bvalid_held", {63'h0, bus.bvalid}, 64'h1);
      check("no_aw_in_resp", {63'h0, bus.awready}, 64'h0);
    end
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    if (n >= 20) check("b_timeout", 0, 1);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    if (bdelay == 0) begin
      s2_start = ap_start; s2_rst = ap_reset; s2_dv = dcr_wr_valid; s2_irq = interrupt;
    end
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin tick(); n++; end
    if (n >= 20) check("ar_timeout", 0, 1);
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin tick(); n++; end
    if (n >= 20) check("r_timeout", 0, 1);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
    ap_done = 0; ap_idle = 0; ap_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_awready", {63'h0, bus.awready}, 64'h1);
    check("rst_arready", {63'h0, bus.arready}, 64'h1);
    check("rst_wready", {63'h0, bus.wready}, 64'h0);
    check("rst_bvalid", {63'h0, bus.bvalid}, 64'h0);
    check("rst_rvalid", {63'h0, bus.rvalid}, 64'h0);
    check("rst_rdata", {32'h0, bus.rdata}, 64'h0);
    check("rst_ap_start", {63'h0, ap_start}, 64'h0);
    check("rst_ap_reset", {63'h0, ap_reset}, 64'h0);
    check("rst_interrupt", {63'h0, interrupt}, 64'h0);
    check("rst_dcr_valid", {63'h0, dcr_wr_valid}, 64'h0);

    axi_read(8'h10, rd, rr); check("dev_lo", rd, 64'h55667788); check("dev_lo_rresp", rr, 0);
    axi_read(8'h14, rd, rr); check("dev_hi", rd, 64'h11223344); check("dev_hi_rresp", rr, 0);
    axi_read(8'h18, rd, rr); check("isa_lo", rd, 64'h0BADC0DE);
    axi_read(8'h1C, rd, rr); check("isa_hi", rd, 64'hCAFEF00D);
    axi_read(8'h40, rd, rr); check("unmapped_rd", rd, 64'h0);

    ap_ready = 1'b1;
    axi_write(8'h00, 32'h1, 4'h0, 0);
    check("start_nostrb", {63'h0, s1_start}, 64'h0);
    axi_write(8'h00, 32'h1, 4'hF, 0);
    check("start_set", {63'h0, s1_start}, 64'h1);
    check("start_clr", {63'h0, s2_start}, 64'h0);
    axi_write(8'h00, 32'h81, 4'h1, 0);
    check("auto_start_set", {63'h0, s1_start}, 64'h1);
    repeat (3) tick();
    check("auto_start_hold", {63'h0, ap_start}, 64'h1);
    axi_read(8'h00, rd, rr); check("ctrl_auto_rd", rd, 64'h89);
    axi_write(8'h00, 32'h0, 4'h1, 0);
    check("auto_off_hold", {63'h0, s1_start}, 64'h1);
    check("auto_off_clr", {63'h0, s2_start}, 64'h0);
    ap_ready = 1'b0;

    ap_idle = 1'b1;
    ap_done = 1'b1; tick(); ap_done = 1'b0;
    axi_read(8'h00, rd, rr); check("done_rd1", rd, 64'h6);
    axi_read(8'h00, rd, rr); check("done_rd2", rd, 64'h4);

    axi_write(8'h04, 32'h1, 4'hF, 0);
    axi_write(8'h08, 32'h1, 4'hF, 0);
    check("irq_idle", {63'h0, interrupt}, 64'h0);
    ap_done = 1'b1; tick(); ap_done = 1'b0;
    check("irq_done", {63'h0, interrupt}, 64'h1);
    axi_read(8'h0C, rd, rr); check("isr_done", rd, 64'h1);
    axi_write(8'h04, 32'h0, 4'hF, 0);
    check("irq_gie_off", {63'h0, interrupt}, 64'h0);
    axi_write(8'h04, 32'h1, 4'hF, 0);
    check("irq_gie_on", {63'h0, interrupt}, 64'h1);
    axi_write(8'h0C, 32'h1, 4'hF, 0);
    check("irq_isr_clr", {63'h0, interrupt}, 64'h0);
    axi_read(8'h00, rd, rr); check("done_rd3", rd, 64'h6);

    axi_write(8'h08, 32'h2, 4'hF, 0);
    ap_ready = 1'b1;
    axi_write(8'h00, 32'h1, 4'hF, 0);
    check("irq_ready", {63'h0, s2_irq}, 64'h1);
    ap_ready = 1'b0;
    axi_read(8'h0C, rd, rr); check("isr_ready", rd, 64'h2);
    axi_write(8'h0C, 32'h2, 4'hF, 0);
    check("irq_ready_clr", {63'h0, interrupt}, 64'h0);

    axi_write(8'h20, 32'h005, 4'hF, 0);
    axi_read(8'h20, rd, rr); check("dcr_addr_rd", rd, 64'h5);
    axi_write(8'h24, 32'hDEADBEEF, 4'h0, 0);
    check("dcr_valid_1", {63'h0, s1_dv}, 64'h1);
    check("dcr_addr", {52'h0, s1_daddr}, 64'h005);
    check("dcr_data", {32'h0, s1_ddata}, 64'hDEADBEEF);
    check("dcr_valid_2", {63'h0, s2_dv}, 64'h0);
    axi_write(8'h20, 32'hAABBCCDD, 4'h2, 0);
    axi_read(8'h20, rd, rr); check("dcr_addr_strb", rd, 64'h0000CC05);
    axi_read(8'h24, rd, rr); check("dcr_data_wo", rd, 64'h0);
    axi_write(8'h40, 32'hFFFFFFFF, 4'hF, 0);
    axi_read(8'h04, rd, rr); check("unmapped_wr", rd, 64'h1);

    axi_write(8'h00, 32'h10, 4'h1, 3);
    check("ap_reset_1", {63'h0, s1_rst}, 64'h1);
    check("ap_reset_2", {63'h0, s2_rst}, 64'h0);
    check("aw_after_b", {63'h0, bus.awready}, 64'h1);
    axi_read(8'h04, rd, rr); check("gie_after_rst", rd, 64'h1);
    axi_read(8'h08, rd, rr); check("ier_after_rst", rd, 64'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
